// File: rtl/instruction_fetch_pkg.sv
// rtl/instruction_fetch_pkg.sv - shared pc-control codes and fetch state encoding
package instruction_fetch_pkg;

   localparam logic [1:0] PC_SEQ    = 2'd0;
   localparam logic [1:0] PC_JUMP   = 2'd1;
   localparam logic [1:0] PC_BRANCH = 2'd2;
   localparam logic [1:0] PC_JR     = 2'd3;

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_HOLD  = 2'd1,
      ST_FAULT = 2'd2
   } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_next_pc.sv
// rtl/instruction_fetch_next_pc.sv - combinational next-pc selection and JR alignment check
module next_pc_calc
   import instruction_fetch_pkg::*;
(
   input  logic [31:0] pc,
   input  logic [1:0]  pc_sel,
   input  logic        branch_taken,
   input  logic [25:0] jump_addr,
   input  logic [31:0] branch_imm,
   input  logic [31:0] jr_target,
   output logic [31:0] next_pc,
   output logic        misaligned
);

   logic [31:0] p4;

   assign p4 = pc + 32'd4;

   always_comb begin
      next_pc = p4;
      case (pc_sel)
         PC_SEQ:    next_pc = p4;
         PC_JUMP:   next_pc = {p4[31:28], jump_addr, 2'b00};
         PC_BRANCH: next_pc = branch_taken ? (p4 + {branch_imm[29:0], 2'b00}) : p4;
         PC_JR:     next_pc = jr_target;
         default:   next_pc = p4;
      endcase
   end

   assign misaligned = (pc_sel == PC_JR) && (jr_target[1:0] != 2'b00);

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - PC register, imem req/ack fetch FSM, instruction latch, retire counter
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic        clk,
   input  logic        reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instruction,
   output logic        instr_valid,
   output logic [31:0] pc_out,
   output logic [31:0] pc_plus4,
   input  logic [1:0]  pc_sel,
   input  logic        branch_taken,
   input  logic [25:0] jump_addr,
   input  logic [31:0] branch_imm,
   input  logic [31:0] jr_target,
   input  logic        exec_done,
   output logic        fetch_fault,
   output logic [31:0] instr_count
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  instr_q, instr_d;
   logic         valid_q, valid_d;
   logic         fault_q, fault_d;
   logic [31:0]  count_q, count_d;

   logic [31:0]  next_pc;
   logic         misaligned;

   next_pc_calc u_next_pc (
      .pc           (pc_q),
      .pc_sel       (pc_sel),
      .branch_taken (branch_taken),
      .jump_addr    (jump_addr),
      .branch_imm   (branch_imm),
      .jr_target    (jr_target),
      .next_pc      (next_pc),
      .misaligned   (misaligned)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      fault_d = fault_q;
      count_d = count_q;
      case (state_q)
         ST_FETCH: begin
            if (imem_ack) begin
               instr_d = imem_rdata;
               valid_d = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            if (exec_done) begin
               valid_d = 1'b0;
               // A misaligned JR parks the core with pc still on the JR itself.
               if (misaligned) begin
                  fault_d = 1'b1;
                  state_d = ST_FAULT;
               end else begin
                  pc_d    = next_pc;
                  count_d = count_q + 32'd1;
                  state_d = ST_FETCH;
               end
            end
         end
         ST_FAULT: begin
            valid_d = 1'b0;
            fault_d = 1'b1;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         instr_q <= 32'd0;
         valid_q <= 1'b0;
         fault_q <= 1'b0;
         count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         fault_q <= fault_d;
         count_q <= count_d;
      end
   end

   assign imem_req    = (state_q == ST_FETCH);
   assign imem_addr   = pc_q;
   assign instruction = instr_q;
   assign instr_valid = valid_q;
   assign pc_out      = pc_q;
   assign pc_plus4    = pc_q + 32'd4;
   assign fetch_fault = fault_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - randomized self-checking bench for instruction_fetch
module tb_instruction_fetch;

   localparam logic [31:0] RESET_PC = 32'h0000_0000;

   logic        clk;
   logic        reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instruction;
   logic        instr_valid;
   logic [31:0] pc_out;
   logic [31:0] pc_plus4;
   logic [1:0]  pc_sel;
   logic        branch_taken;
   logic [25:0] jump_addr;
   logic [31:0] branch_imm;
   logic [31:0] jr_target;
   logic        exec_done;
   logic        fetch_fault;
   logic [31:0] instr_count;

   int total = 0;
   int bad   = 0;

   logic [31:0] m_pc;
   logic [31:0] m_count;
   logic [31:0] m_instr;

   instruction_fetch #(.RESET_PC(RESET_PC)) dut (
      .clk          (clk),
      .reset        (reset),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_rdata   (imem_rdata),
      .instruction  (instruction),
      .instr_valid  (instr_valid),
      .pc_out       (pc_out),
      .pc_plus4     (pc_plus4),
      .pc_sel       (pc_sel),
      .branch_taken (branch_taken),
      .jump_addr    (jump_addr),
      .branch_imm   (branch_imm),
      .jr_target    (jr_target),
      .exec_done    (exec_done),
      .fetch_fault  (fetch_fault),
      .instr_count  (instr_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference next-pc from the architectural rules, written with plain arithmetic.
   function automatic logic [31:0] ref_next(input logic [31:0] pc, input logic [1:0] sel,
                                            input logic taken, input logic [25:0] ja,
                                            input logic [31:0] imm, input logic [31:0] jr);
      logic [31:0] p4;
      p4 = pc + 32'd4;
      if (sel == 2'd0)      return p4;
      else if (sel == 2'd1) return (p4 & 32'hF000_0000) + ({6'd0, ja} * 32'd4);
      else if (sel == 2'd2) return taken ? p4 + imm * 32'd4 : p4;
      else                  return jr;
   endfunction

   task automatic scramble_ctrl();
      pc_sel       = 2'($urandom);
      branch_taken = 1'($urandom);
      jump_addr    = 26'($urandom);
      branch_imm   = $urandom;
      jr_target    = $urandom;
   endtask

   task automatic do_reset();
      reset      = 1'b1;
      exec_done  = 1'($urandom);
      imem_ack   = 1'b1;
      imem_rdata = $urandom;
      step();
      reset     = 1'b0;
      imem_ack  = 1'b0;
      exec_done = 1'b0;
      m_pc      = RESET_PC;
      m_count   = 32'd0;
      m_instr   = 32'd0;
      chk("rst_req", 32'(imem_req), 32'd1);
      chk("rst_addr", imem_addr, RESET_PC);
      chk("rst_valid", 32'(instr_valid), 32'd0);
      chk("rst_instr", instruction, 32'd0);
      chk("rst_fault", 32'(fetch_fault), 32'd0);
      chk("rst_count", instr_count, 32'd0);
   endtask

   task automatic fetch_one(input logic [31:0] rdata, input int waits);
      exec_done = 1'($urandom);
      for (int i = 0; i < waits; i++) begin
         chk("wait_req", 32'(imem_req), 32'd1);
         chk("wait_addr", imem_addr, m_pc);
         imem_ack = 1'b0;
         step();
      end
      chk("fetch_req", 32'(imem_req), 32'd1);
      chk("fetch_addr", imem_addr, m_pc);
      imem_ack   = 1'b1;
      imem_rdata = rdata;
      step();
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      exec_done  = 1'b0;
      m_instr    = rdata;
      chk("lat_instr", instruction, rdata);
      chk("lat_valid", 32'(instr_valid), 32'd1);
      chk("lat_req", 32'(imem_req), 32'd0);
      chk("lat_pc", pc_out, m_pc);
      chk("lat_pc4", pc_plus4, m_pc + 32'd4);
   endtask

   // Returns 1 when the retire faulted.
   task automatic retire(input logic [1:0] sel, input logic taken, input logic [25:0] ja,
                         input logic [31:0] imm, input logic [31:0] jr, input int holds,
                         output bit faulted);
      for (int i = 0; i < holds; i++) begin
         scramble_ctrl();
         imem_ack   = 1'($urandom);
         imem_rdata = $urandom;
         step();
         chk("hold_instr", instruction, m_instr);
         chk("hold_valid", 32'(instr_valid), 32'd1);
         chk("hold_pc", pc_out, m_pc);
      end
      imem_ack     = 1'b0;
      pc_sel       = sel;
      branch_taken = taken;
      jump_addr    = ja;
      branch_imm   = imm;
      jr_target    = jr;
      exec_done    = 1'b1;
      step();
      exec_done = 1'b0;
      scramble_ctrl();
      faulted = (sel == 2'd3) && (jr % 4 != 0);
      if (faulted) begin
         chk("flt_fault", 32'(fetch_fault), 32'd1);
         chk("flt_req", 32'(imem_req), 32'd0);
         chk("flt_valid", 32'(instr_valid), 32'd0);
         chk("flt_count", instr_count, m_count);
         chk("flt_pc", pc_out, m_pc);
         for (int i = 0; i < 3; i++) begin
            exec_done  = 1'($urandom);
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            step();
            chk("flt_stay", 32'(fetch_fault), 32'd1);
            chk("flt_stay_req", 32'(imem_req), 32'd0);
            chk("flt_stay_pc", pc_out, m_pc);
         end
         exec_done = 1'b0;
         imem_ack  = 1'b0;
      end else begin
         m_pc    = ref_next(m_pc, sel, taken, ja, imm, jr);
         m_count = m_count + 32'd1;
         chk("ret_valid", 32'(instr_valid), 32'd0);
         chk("ret_count", instr_count, m_count);
         chk("ret_req", 32'(imem_req), 32'd1);
         chk("ret_addr", imem_addr, m_pc);
      end
   endtask

   initial begin
      bit f;
      reset        = 1'b1;
      imem_ack     = 1'b0;
      imem_rdata   = 32'd0;
      exec_done    = 1'b0;
      scramble_ctrl();
      step();
      do_reset();

      fetch_one(32'h2008_0005, 2);
      chk("first_pc4", pc_plus4, 32'd4);
      retire(2'd0, 1'b0, 26'd0, 32'd0, 32'd0, 0, f);
      chk("seq_addr4", imem_addr, 32'd4);
      chk("seq_cnt1", instr_count, 32'd1);
      fetch_one($urandom, 0);
      retire(2'd0, 1'b0, 26'd0, 32'd0, 32'd0, 1, f);
      fetch_one($urandom, 1);
      retire(2'd2, 1'b1, 26'd0, 32'hFFFF_FFFE, 32'd0, 0, f);
      chk("br_taken", imem_addr, 32'd4);
      fetch_one($urandom, 0);
      retire(2'd0, 1'b0, 26'd0, 32'd0, 32'd0, 0, f);
      fetch_one($urandom, 0);
      retire(2'd2, 1'b0, 26'd0, 32'hFFFF_FFFE, 32'd0, 2, f);
      chk("br_not_taken", imem_addr, 32'd12);
      fetch_one($urandom, 0);
      retire(2'd3, 1'b0, 26'd0, 32'd0, 32'h1000_0010, 0, f);
      fetch_one($urandom, 0);
      retire(2'd1, 1'b0, 26'h000_0040, 32'd0, 32'd0, 0, f);
      chk("jump", imem_addr, 32'h1000_0100);
      fetch_one($urandom, 0);
      retire(2'd3, 1'b0, 26'd0, 32'd0, 32'hFFFF_FFFC, 0, f);
      fetch_one($urandom, 1);
      retire(2'd0, 1'b0, 26'd0, 32'd0, 32'd0, 0, f);
      chk("wrap", imem_addr, 32'd0);
      fetch_one($urandom, 0);
      retire(2'd3, 1'b0, 26'd0, 32'd0, 32'h0000_0400, 0, f);
      chk("jr_aligned", imem_addr, 32'h0000_0400);

      // Reset during a fetch wait, with an ack offered in the reset cycle itself.
      imem_ack = 1'b0;
      step();
      do_reset();
      fetch_one($urandom, 0);
      retire(2'd3, 1'b0, 26'd0, 32'd0, 32'h0000_0402, 1, f);
      chk("jr_misaligned", 32'(f), 32'd1);
      do_reset();

      for (int n = 0; n < 300; n++) begin
         logic [1:0]  sel;
         logic [31:0] jr;
         sel = 2'($urandom);
         jr  = $urandom;
         if ($urandom_range(0, 7) != 0) jr[1:0] = 2'b00;
         fetch_one($urandom, $urandom_range(0, 3));
         retire(sel, 1'($urandom), 26'($urandom), $urandom, jr, $urandom_range(0, 2), f);
         if (f) do_reset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
